vn_debiaser: RTL and testbench
==============================

VN_DEBIASER -- requirements
Module: vn_debiaser

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on raw input, minimum 2.
REQ-002 SHALL have parameter DIV, default 4: sample every DIV clocks, range 1..65535.
REQ-003 SHALL have parameter REP_LIMIT, default 32: consecutive identical samples that trip the health test, range 2..65535.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state on posedge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port raw, input, 1 bit: asynchronous entropy bit (ring oscillator / metastable sampler).
REQ-007 SHALL have port health_clr, input, 1 bit: synchronous clear of the health state.
REQ-008 SHALL have port random, output, 1 bit: debiased bit, forced 0 when random_valid=0, so it XORs directly into an LFSR random input.
REQ-009 SHALL have port random_valid, output, 1 bit: one-cycle pulse marking a new debiased bit.
REQ-010 SHALL have port health_fail, output, 1 bit: sticky repetition-count failure flag.

Function
REQ-011 SHALL pass raw through SYNC_STAGES flops; the last stage is the sample source s.
REQ-012 SHALL run a tick counter 0..DIV-1 that wraps; a sample tick occurs when the count equals DIV-1 (DIV=1: every cycle).
REQ-013 SHALL implement FSM EMPTY/HAVE_FIRST: on a tick in EMPTY, latch s as first bit and go HAVE_FIRST; on a tick in HAVE_FIRST, compare s with the first bit and return to EMPTY.
REQ-014 SHALL, on the compare tick, output pair (0,1) as 0 and pair (1,0) as 1, and discard pairs (0,0) and (1,1) with no output.
REQ-015 SHALL register outputs: random_valid high and random = first bit for exactly the one cycle after the second tick of an unequal pair.
REQ-016 SHALL keep a repetition counter: reset to 1 when a tick's sample differs from the previous tick's sample; otherwise increment, saturating at REP_LIMIT.
REQ-017 SHALL set health_fail the cycle after the counter reaches REP_LIMIT; it stays set until health_clr or reset.
REQ-018 SHALL suppress random_valid (and random) while health_fail=1; the FSM keeps running.
REQ-019 SHALL, on health_clr, clear health_fail, set the repetition counter to 1, and force the FSM to EMPTY, discarding any half pair.
REQ-020 SHALL give the failure trip priority over health_clr when both happen in the same cycle: health_fail is set.
REQ-021 SHALL treat the first tick after reset as having no previous sample: counter=1.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear all synchronizer flops, tick counter, FSM (EMPTY), first bit, repetition counter, random, random_valid and health_fail to 0.
REQ-023 SHALL discard any half pair on reset mid-operation; the first output after release needs two fresh ticks.

Configuration
REQ-024 SHALL compile the health test in with macro VN_DEBIASER_HEALTH_EN: REQ-016..REQ-021 are active.
REQ-025 SHALL, without VN_DEBIASER_HEALTH_EN, tie health_fail to 0, omit the repetition counter, and make health_clr only force the FSM to EMPTY.

Structure
REQ-026 SHALL place FSM state encodings (EMPTY=0, HAVE_FIRST=1) and tick/repetition counter width constants in shared package vn_debiaser_pkg.
REQ-027 SHALL implement the synchronizer as sub-module sync_ff (parameter STAGES, async active-low reset).

Verification
REQ-028 DIV=1, synchronized s sequence 0,1 -> random_valid one cycle after the second tick with random=0; sequence 1,0 -> random=1.
REQ-029 DIV=4, s sequence 1,1,0,0 -> no random_valid pulse in 16 clocks; random stays 0.
REQ-030 Health enabled, REP_LIMIT=32, DIV=1, raw held 1 -> health_fail rises one cycle after the 32nd identical tick; random_valid stays 0 until health_clr.
REQ-031 Tick with first bit latched, then rst_n low for one cycle -> all outputs 0 immediately; a fresh pair 1,0 after release -> random=1.
REQ-032 health_clr in the same cycle as the 32nd identical tick -> health_fail=1 in the next cycle.
REQ-033 Macro undefined, raw held 0 for 100 ticks -> health_fail stays 0 and no random_valid.

Source files
------------

// File: rtl/vn_debiaser_pkg.sv
// Shared types and width constants for the von Neumann debiaser.
package vn_debiaser_pkg;

    typedef enum logic {
        EMPTY      = 1'b0,
        HAVE_FIRST = 1'b1
    } vn_state_e;

    localparam int unsigned TICK_W = 16;
    localparam int unsigned REP_W  = 16;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous bit.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vn_debiaser.sv
// Von Neumann debiaser with decimated sampling of a synchronized entropy bit.
// Define VN_DEBIASER_HEALTH_EN to build in the repetition-count health test.
module vn_debiaser
    import vn_debiaser_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DIV         = 4,
    parameter int unsigned REP_LIMIT   = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic health_clr,
    output logic random,
    output logic random_valid,
    output logic health_fail
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);

    logic              s;
    logic              tick;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    vn_state_e         state_q, state_d;
    logic              first_q, first_d;
    logic              random_q, random_d;
    logic              valid_q, valid_d;
    logic              fail_next;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (raw),
        .q    (s)
    );

    assign tick = (tick_cnt_q == TICK_LAST);

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        state_d    = state_q;
        first_d    = first_q;
        random_d   = 1'b0;
        valid_d    = 1'b0;
        if (health_clr) begin
            state_d = EMPTY;
        end else if (tick) begin
            case (state_q)
                EMPTY: begin
                    first_d = s;
                    state_d = HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    state_d = EMPTY;
                    // Next-cycle failure also gates, so valid never coincides with health_fail.
                    if (s != first_q && !fail_next) begin
                        valid_d  = 1'b1;
                        random_d = first_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            state_q    <= EMPTY;
            first_q    <= 1'b0;
            random_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            first_q    <= first_d;
            random_q   <= random_d;
            valid_q    <= valid_d;
        end
    end

`ifdef VN_DEBIASER_HEALTH_EN
    localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic             health_fail_q, health_fail_d;
    logic             trip;

    always_comb begin
        rep_d       = rep_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        trip        = 1'b0;
        if (tick) begin
            prev_d      = s;
            have_prev_d = 1'b1;
            if (!have_prev_q || s != prev_q) begin
                rep_d = REP_W'(1);
            end else if (rep_q != REP_MAX) begin
                rep_d = rep_q + REP_W'(1);
            end
            trip = (rep_d == REP_MAX);
        end
        // A trip is evaluated before the clear so it wins a same-cycle collision.
        if (health_clr) begin
            rep_d = REP_W'(1);
        end
        health_fail_d = trip | (health_fail_q & ~health_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q         <= '0;
            prev_q        <= 1'b0;
            have_prev_q   <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            rep_q         <= rep_d;
            prev_q        <= prev_d;
            have_prev_q   <= have_prev_d;
            health_fail_q <= health_fail_d;
        end
    end

    assign fail_next   = health_fail_d;
    assign health_fail = health_fail_q;
`else
    assign fail_next   = 1'b0;
    assign health_fail = 1'b0;
`endif

    assign random       = random_q;
    assign random_valid = valid_q;

endmodule

// File: tb/tb_vn_debiaser.sv
// Directed bench for vn_debiaser: DIV=1 and DIV=4 instances, scoreboard on the DIV=1 output.
module tb_vn_debiaser;

    logic clk = 1'b0;
    logic rst_n;
    logic raw1, clr1, rnd1, val1, hf1;
    logic raw4, clr4, rnd4, val4, hf4;

    int   checks = 0;
    int   fails  = 0;
    logic exp_q[$];
    logic exp_bit;

    always #5 clk = ~clk;

    vn_debiaser #(
        .SYNC_STAGES(2),
        .DIV        (1),
        .REP_LIMIT  (32)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (raw1),
        .health_clr  (clr1),
        .random      (rnd1),
        .random_valid(val1),
        .health_fail (hf1)
    );

    vn_debiaser #(
        .SYNC_STAGES(2),
        .DIV        (4),
        .REP_LIMIT  (32)
    ) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw         (raw4),
        .health_clr  (clr4),
        .random      (rnd4),
        .random_valid(val4),
        .health_fail (hf4)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Aligns the pair with health_clr, then presents a and b on two consecutive ticks.
    task automatic send_pair(input logic a, input logic b);
        raw1 = a;
        clr1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 raw1 = b;
        @(posedge clk);
        #1 clr1 = 1'b0;
        if (a != b) exp_q.push_back(a);
        repeat (2) @(posedge clk);
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (val1) begin
            chk("valid_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                exp_bit = exp_q.pop_front();
                chk("random_bit", rnd1, exp_bit);
            end
        end else begin
            chk("idle_random_zero", rnd1, 1'b0);
        end
    end

    initial begin
        rst_n = 1'b0;
        raw1  = 1'b0;
        clr1  = 1'b0;
        raw4  = 1'b1;
        clr4  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid1", val1, 1'b0);
        chk("rst_random1", rnd1, 1'b0);
        chk("rst_fail1", hf1, 1'b0);
        chk("rst_valid4", val4, 1'b0);
        chk("rst_random4", rnd4, 1'b0);
        chk("rst_fail4", hf4, 1'b0);
        rst_n = 1'b1;

        // DIV=4: ticks at edges 4,8,..; s = 1,1,0,0 (no output), then 1,0 -> bit 1 after edge 24.
        for (int n = 1; n <= 28; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("div4_valid", val4, n == 24);
            chk("div4_random", rnd4, n == 24);
            raw4 = ((n + 1) <= 8) || ((n + 1) >= 17 && (n + 1) <= 20);
        end

        send_pair(1'b0, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b0);
        send_pair(1'b1, 1'b1);
        send_pair(1'b1, 1'b0);
        send_pair(1'b0, 1'b1);

        // Half pair latched, then reset: the stale first bit must not pair with post-reset samples.
        raw1 = 1'b1;
        clr1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 clr1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        raw1  = 1'b0;
        #1;
        chk("midrst_valid", val1, 1'b0);
        chk("midrst_random", rnd1, 1'b0);
        chk("midrst_fail", hf1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_pair(1'b1, 1'b0);

`ifdef VN_DEBIASER_HEALTH_EN
        // raw held 1: s is 0,0 on the first two ticks, then 1 from edge 3; 32nd identical tick at edge 34.
        @(negedge clk);
        rst_n = 1'b0;
        raw1  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 34; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 33) chk("fail_before_limit", hf1, 1'b0);
            if (n == 34) chk("fail_at_limit", hf1, 1'b1);
        end
        for (int i = 0; i < 12; i++) begin
            raw1 = ~raw1;
            @(negedge clk);
        end
        chk("fail_sticky", hf1, 1'b1);

        @(negedge clk);
        rst_n = 1'b0;
        raw1  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 33; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 33) chk("fail_before_limit2", hf1, 1'b0);
        end
        clr1 = 1'b1;
        @(posedge clk);
        #1 clr1 = 1'b0;
        @(negedge clk);
        chk("trip_beats_clear", hf1, 1'b1);
        send_pair(1'b1, 1'b0);
        chk("fail_cleared", hf1, 1'b0);
`else
        @(negedge clk);
        rst_n = 1'b0;
        raw1  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_health_fail", hf1, 1'b0);
        end
`endif

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
